i2c_slave_regbank: RTL and testbench

Parametrised I2C target with an internal byte-wide register bank and an auto-incrementing register pointer. It is the successor to the single-byte slave and supports multi-byte bursts, combined write-pointer/repeated-START/read transfers and pointer wrap. It sits on the shared SDA/SCL bus, driving SDA through sda_out/sda_oe into the tristate. The register bank is also exposed to a local host port.

---
 rtl/i2c_slave_regbank.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regbank.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regbank.sv
// I2C target with byte register bank, auto-incrementing wrapping pointer and local host port.
// Latency: bus inputs pass SYNC_STAGES flops; SDA changes one cycle after a detected SCL fall.
// Backpressure: none; every data byte is ACKed, and the host port is written on any clk edge.
module i2c_slave_regbank #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         PTR_W       = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl,
    input  logic             sda,
    output logic             sda_out,
    output logic             sda_oe,
    input  logic             host_we,
    input  logic [PTR_W-1:0] host_addr,
    input  logic [7:0]       host_wdata,
    output logic [7:0]       host_rdata,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             sh_q, sh_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   phase_q, phase_d;
    logic                   rw_q, rw_d;
    logic                   busy_q, busy_d;
    logic                   oe_q, oe_d;
    logic                   out_q, out_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic [PTR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];

    logic             scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]       rx_byte;
    logic [PTR_W-1:0] ptr_next;
    logic             ptr_ok, host_ok, commit;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {sh_q[6:0], sda_s};
    assign ptr_next  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
    assign ptr_ok    = {1'b0, rx_byte} < 9'(NUM_REGS);
    assign host_ok   = int'(host_addr) < NUM_REGS;

    assign host_rdata = host_ok ? regs_q[host_addr] : 8'h00;
    assign sda_oe     = oe_q;
    assign sda_out    = out_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        ptr_d   = ptr_q;
        phase_d = phase_q;
        rw_d    = rw_q;
        busy_d  = busy_q;
        oe_d    = oe_q;
        commit  = 1'b0;
        if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            state_d = S_ADDR_ACK;
                            phase_d = 1'b0;
                            rw_d    = rx_byte[0];
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // phase 0: waiting for the fall that starts the ACK; phase 1: ACK is on the bus
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        oe_d    = 1'b1;
                    end else if (rw_q) begin
                        sh_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        cnt_d   = '0;
                        state_d = S_RD_DATA;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_PTR;
                    end
                end
                S_PTR: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (ptr_ok) begin
                            ptr_d   = rx_byte[PTR_W-1:0];
                            phase_d = 1'b0;
                            state_d = S_WR_ACK;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    sh_d  = rx_byte;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        commit  = 1'b1;
                        ptr_d   = ptr_next;
                        phase_d = 1'b0;
                        state_d = S_WR_ACK;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        oe_d    = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WR_DATA;
                    end
                end
                // the byte rotates so sh_q[7] is always the bit currently on the bus
                S_RD_DATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        oe_d    = 1'b0;
                        ptr_d   = ptr_next;
                        phase_d = 1'b0;
                        state_d = S_RD_ACK;
                    end else begin
                        sh_d  = {sh_q[6:0], sh_q[7]};
                        oe_d  = ~sh_q[6];
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) state_d = S_WAIT_STOP;
                        else       phase_d = 1'b1;
                    end else if (scl_fall && phase_q) begin
                        sh_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        cnt_d   = '0;
                        state_d = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
        out_d       = ~oe_d;
        wr_strobe_d = commit;
        wr_addr_d   = commit ? ptr_q : wr_addr_q;
        wr_data_d   = commit ? rx_byte : wr_data_q;
    end

    // I2C commit is applied last so it wins a same-register collision with the host
    always_comb begin
        regs_d = regs_q;
        if (host_we && host_ok) regs_d[host_addr] = host_wdata;
        if (commit)             regs_d[ptr_q]     = rx_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            cnt_q       <= '0;
            sh_q        <= '0;
            ptr_q       <= '0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            oe_q        <= 1'b0;
            out_q       <= 1'b1;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            regs_q      <= '{default: 8'h00};
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ptr_q       <= ptr_d;
            phase_q     <= phase_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            oe_q        <= oe_d;
            out_q       <= out_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            regs_q      <= regs_d;
        end
    end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: a 16-register target at 0x42 and a 12-register target at 0x50
// share one wired-AND bus driven by a bit-level master model.
module tb_i2c_slave_regbank;
    localparam int SYNC = 2;

    logic clk = 1'b0, reset = 1'b0, scl = 1'b1, m_sda = 1'b1;
    logic sda;
    logic sda_out, sda_oe, busy, wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, host_rdata;
    logic host_we = 1'b0;
    logic [3:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic sda_out_b, sda_oe_b, busy_b, wr_strobe_b;
    logic [3:0] wr_addr_b;
    logic [7:0] wr_data_b, host_rdata_b;
    logic host_we_b = 1'b0;
    logic [3:0] host_addr_b = '0;
    logic [7:0] host_wdata_b = '0;

    assign sda = m_sda & ~(sda_oe & ~sda_out) & ~(sda_oe_b & ~sda_out_b);
    always #5 clk = ~clk;

    i2c_slave_regbank #(.SLAVE_ADDR(7'h42), .NUM_REGS(16), .PTR_W(4), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .sda_out(sda_out), .sda_oe(sda_oe),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy));

    i2c_slave_regbank #(.SLAVE_ADDR(7'h50), .NUM_REGS(12), .PTR_W(4), .SYNC_STAGES(SYNC)) dut12 (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .sda_out(sda_out_b), .sda_oe(sda_oe_b),
        .host_we(host_we_b), .host_addr(host_addr_b), .host_wdata(host_wdata_b),
        .host_rdata(host_rdata_b), .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b));

    int n_vec = 0, n_bad = 0;
    logic [11:0] wl[$];
    int wl12_n = 0;
    logic mon_en = 1'b0, oe_seen = 1'b0, busy_seen = 1'b0;

    always @(negedge clk) begin
        if (wr_strobe) wl.push_back({wr_addr, wr_data});
        if (wr_strobe_b) wl12_n++;
        if (mon_en && sda_oe) oe_seen = 1'b1;
        if (mon_en && busy) busy_seen = 1'b1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_bit(input logic b, output logic s);
        m_sda = b;
        tick(4);
        scl = 1'b1;
        tick(2);
        s = sda;
        tick(2);
        scl = 1'b0;
        tick(4);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(4);
        scl = 1'b1;   tick(4);
        m_sda = 1'b0; tick(4);
        scl = 1'b0;   tick(4);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(4);
        scl = 1'b1;   tick(4);
        m_sda = 1'b1; tick(4);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) scl_bit(b[i], s);
        scl_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            scl_bit(1'b1, s);
            b[i] = s;
        end
        scl_bit(nack, s);
    endtask

    // host write lands in exactly the cycle the 8th SCL rise is seen by the target
    task automatic col_byte(input logic [7:0] b, input logic [3:0] ha, input logic [7:0] hd,
                            output logic ack);
        logic s;
        for (int i = 7; i >= 1; i--) scl_bit(b[i], s);
        m_sda = b[0];
        tick(4);
        scl = 1'b1;
        tick(SYNC);
        host_addr = ha; host_wdata = hd; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        tick(1);
        scl = 1'b0;
        tick(4);
        scl_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic check_reg(input string nm, input logic d12, input logic [3:0] a,
                             input logic [7:0] exp);
        if (d12) begin
            host_addr_b = a; #1;
            check(nm, host_rdata_b, exp);
        end else begin
            host_addr = a; #1;
            check(nm, host_rdata, exp);
        end
    endtask

    task automatic check_log(input string nm, input int n, input logic [11:0] e0,
                             input logic [11:0] e1, input logic [11:0] e2);
        check({nm, " strobe count"}, wl.size(), n);
        if (wl.size() == n)
            for (int i = 0; i < n; i++)
                check({nm, " strobe"}, wl[i], (i == 0) ? e0 : (i == 1) ? e1 : e2);
        wl.delete();
    endtask

    typedef struct {
        logic       d12;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } hvec_t;

    hvec_t tbl[9];
    logic ack;
    logic [7:0] rb;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 4'd5,  8'h5A, 8'h5A};
        tbl[1] = '{1'b0, 1'b1, 4'd9,  8'h3C, 8'h3C};
        tbl[2] = '{1'b0, 1'b0, 4'd5,  8'hFF, 8'h5A};
        tbl[3] = '{1'b0, 1'b0, 4'd1,  8'hFF, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 4'd11, 8'hE7, 8'hE7};
        tbl[5] = '{1'b1, 1'b1, 4'd12, 8'h99, 8'h00};
        tbl[6] = '{1'b1, 1'b1, 4'd15, 8'h99, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 4'd11, 8'h00, 8'hE7};
        tbl[8] = '{1'b0, 1'b1, 4'd9,  8'h00, 8'h00};

        tick(3);
        check("reset sda_oe", sda_oe, 1'b0);
        check("reset sda_out", sda_out, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset wr_strobe", wr_strobe, 1'b0);
        check("reset wr_addr", wr_addr, 4'h0);
        check("reset wr_data", wr_data, 8'h00);
        reset = 1'b1;
        tick(4);

        foreach (tbl[i]) begin
            if (tbl[i].d12) begin
                host_addr_b = tbl[i].addr; host_wdata_b = tbl[i].wdata; host_we_b = tbl[i].we;
            end else begin
                host_addr = tbl[i].addr; host_wdata = tbl[i].wdata; host_we = tbl[i].we;
            end
            tick(1);
            host_we = 1'b0; host_we_b = 1'b0;
            check_reg("host table", tbl[i].d12, tbl[i].addr, tbl[i].exp);
        end

        // burst write from pointer 2
        i2c_start();
        wr_byte(8'h84, ack); check("t1 addr ack", ack, 1'b1);
        wr_byte(8'h02, ack); check("t1 ptr ack", ack, 1'b1);
        check("t1 busy", busy, 1'b1);
        wr_byte(8'hAA, ack); check("t1 d0 ack", ack, 1'b1);
        wr_byte(8'hBB, ack); check("t1 d1 ack", ack, 1'b1);
        wr_byte(8'hCC, ack); check("t1 d2 ack", ack, 1'b1);
        i2c_stop();
        check("t1 busy after stop", busy, 1'b0);
        check_reg("t1 reg2", 1'b0, 4'd2, 8'hAA);
        check_reg("t1 reg3", 1'b0, 4'd3, 8'hBB);
        check_reg("t1 reg4", 1'b0, 4'd4, 8'hCC);
        check_log("t1", 3, {4'd2, 8'hAA}, {4'd3, 8'hBB}, {4'd4, 8'hCC});
        i2c_start();
        wr_byte(8'h85, ack); check("t1 read ack", ack, 1'b1);
        rd_byte(1'b1, rb);   check("t1 read ptr5", rb, 8'h5A);
        i2c_stop();

        // combined pointer write, repeated START, burst read
        i2c_start();
        wr_byte(8'h84, ack); check("t2 addr ack", ack, 1'b1);
        wr_byte(8'h02, ack); check("t2 ptr ack", ack, 1'b1);
        i2c_start();
        wr_byte(8'h85, ack); check("t2 raddr ack", ack, 1'b1);
        rd_byte(1'b0, rb);   check("t2 rd0", rb, 8'hAA);
        rd_byte(1'b0, rb);   check("t2 rd1", rb, 8'hBB);
        rd_byte(1'b1, rb);   check("t2 rd2", rb, 8'hCC);
        check("t2 released after nack", sda_oe, 1'b0);
        i2c_stop();
        check_log("t2", 0, '0, '0, '0);

        // foreign address
        oe_seen = 1'b0; busy_seen = 1'b0; mon_en = 1'b1;
        i2c_start();
        wr_byte(8'h86, ack); check("t3 addr nack", ack, 1'b0);
        wr_byte(8'h11, ack);
        wr_byte(8'h22, ack);
        i2c_stop();
        mon_en = 1'b0;
        check("t3 sda_oe seen", oe_seen, 1'b0);
        check("t3 busy seen", busy_seen, 1'b0);
        check_log("t3", 0, '0, '0, '0);
        check_reg("t3 reg2", 1'b0, 4'd2, 8'hAA);

        // pointer wrap
        host_addr = 4'd1; host_wdata = 8'hC3; host_we = 1'b1; tick(1); host_we = 1'b0;
        i2c_start();
        wr_byte(8'h84, ack); check("t4 addr ack", ack, 1'b1);
        wr_byte(8'h0F, ack); check("t4 ptr ack", ack, 1'b1);
        wr_byte(8'h11, ack); check("t4 d0 ack", ack, 1'b1);
        wr_byte(8'h22, ack); check("t4 d1 ack", ack, 1'b1);
        i2c_stop();
        check_reg("t4 reg15", 1'b0, 4'd15, 8'h11);
        check_reg("t4 reg0", 1'b0, 4'd0, 8'h22);
        check_log("t4", 2, {4'd15, 8'h11}, {4'd0, 8'h22}, '0);
        i2c_start();
        wr_byte(8'h85, ack); check("t4 read ack", ack, 1'b1);
        rd_byte(1'b1, rb);   check("t4 read ptr1", rb, 8'hC3);
        i2c_stop();

        // 12-register target: out-of-range pointer, then wrap at 11
        i2c_start();
        wr_byte(8'hA0, ack); check("t4b addr ack", ack, 1'b1);
        wr_byte(8'h0C, ack); check("t4b ptr12 nack", ack, 1'b0);
        wr_byte(8'h66, ack); check("t4b data nack", ack, 1'b0);
        i2c_stop();
        check("t4b no strobe", wl12_n, 0);
        check_reg("t4b reg11 kept", 1'b1, 4'd11, 8'hE7);
        i2c_start();
        wr_byte(8'hA0, ack); check("t4b addr2 ack", ack, 1'b1);
        wr_byte(8'h0B, ack); check("t4b ptr11 ack", ack, 1'b1);
        wr_byte(8'h5C, ack); check("t4b d0 ack", ack, 1'b1);
        wr_byte(8'h6D, ack); check("t4b d1 ack", ack, 1'b1);
        i2c_stop();
        check("t4b strobes", wl12_n, 2);
        check_reg("t4b reg11", 1'b1, 4'd11, 8'h5C);
        check_reg("t4b reg0", 1'b1, 4'd0, 8'h6D);
        wl.delete();

        // host/I2C collisions: same register then different register
        i2c_start();
        wr_byte(8'h84, ack); check("t5 addr ack", ack, 1'b1);
        wr_byte(8'h03, ack); check("t5 ptr ack", ack, 1'b1);
        col_byte(8'h77, 4'd3, 8'h55, ack); check("t5 d0 ack", ack, 1'b1);
        col_byte(8'h78, 4'd7, 8'h99, ack); check("t5 d1 ack", ack, 1'b1);
        i2c_stop();
        check_reg("t5 reg3 i2c wins", 1'b0, 4'd3, 8'h77);
        check_reg("t5 reg4", 1'b0, 4'd4, 8'h78);
        check_reg("t5 reg7 host", 1'b0, 4'd7, 8'h99);
        check_log("t5", 2, {4'd3, 8'h77}, {4'd4, 8'h78}, '0);

        // reset while the address ACK is on the bus
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            logic s;
            logic [7:0] a;
            a = 8'h84;
            scl_bit(a[i], s);
        end
        m_sda = 1'b1; tick(4);
        scl = 1'b1;   tick(2);
        check("t5 ack driven", sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        check("t5 reset releases sda", sda_oe, 1'b0);
        check("t5 reset busy", busy, 1'b0);
        for (int i = 0; i < 16; i++) check_reg("t5 reset reg", 1'b0, 4'(i), 8'h00);
        for (int i = 0; i < 12; i++) check_reg("t5 reset reg12", 1'b1, 4'(i), 8'h00);
        scl = 1'b1; m_sda = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
